// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS BCD countdown on the 2 Hz tick with set, pause, expiry flag and 1 Hz blink
module countdown_timer (
   input  logic       CLK2,
   input  logic       RESET,
   input  logic       ADJ,
   input  logic       SEL,
   input  logic       START,
   input  logic       PAUSE,
   output logic [3:0] d0,
   output logic [3:0] d1,
   output logic [3:0] d2,
   output logic [3:0] d3,
   output logic       done,
   output logic       blank
);
   typedef enum logic [1:0] {SET, RUN, HOLD, EXPIRED} state_t;
   state_t      state;
   logic        phase;
   logic        start_q;
   logic        start_rise;
   logic        is_zero;
   logic [15:0] dec;
   logic [7:0]  inc_sec;
   logic [7:0]  inc_min;
   // one-second BCD borrow chain and 00..59 field increments
   always_comb begin
      start_rise = START & ~start_q;
      is_zero    = {d3, d2, d1, d0} == 16'h0000;
      dec[3:0]   = d0 != 4'd0 ? d0 - 4'd1 : 4'd9;
      dec[7:4]   = d0 != 4'd0 ? d1 : (d1 != 4'd0 ? d1 - 4'd1 : 4'd5);
      dec[11:8]  = (d0 != 4'd0 || d1 != 4'd0) ? d2 : (d2 != 4'd0 ? d2 - 4'd1 : 4'd9);
      dec[15:12] = (d0 == 4'd0 && d1 == 4'd0 && d2 == 4'd0) ? d3 - 4'd1 : d3;
      inc_sec    = d0 == 4'd9 ? {d1 == 4'd5 ? 4'd0 : d1 + 4'd1, 4'd0} : {d1, d0 + 4'd1};
      inc_min    = d2 == 4'd9 ? {d3 == 4'd5 ? 4'd0 : d3 + 4'd1, 4'd0} : {d3, d2 + 4'd1};
   end
   // mode FSM with registered digits and flags; phase halves the 2 Hz tick into seconds
   always_ff @(posedge CLK2) begin
      if (RESET) begin
         state             <= SET;
         {d3, d2, d1, d0}  <= 16'h0000;
         phase             <= 1'b0;
         done              <= 1'b0;
         blank             <= 1'b0;
         start_q           <= 1'b0;
      end else begin
         start_q <= START;
         case (state)
            SET:
               if (ADJ) begin
                  if (SEL) {d1, d0} <= inc_sec;
                  else     {d3, d2} <= inc_min;
               end else if (start_rise && !is_zero) begin
                  state <= RUN;
                  phase <= 1'b0;
               end
            RUN:
               if (PAUSE) state <= HOLD;
               else if (!phase) phase <= 1'b1;
               else begin
                  phase            <= 1'b0;
                  {d3, d2, d1, d0} <= dec;
                  if (dec == 16'h0000) begin
                     state <= EXPIRED;
                     done  <= 1'b1;
                     blank <= 1'b0;
                  end
               end
            HOLD:
               if (!PAUSE) state <= RUN;
               else if (ADJ) state <= SET;
            EXPIRED:
               if (start_rise || ADJ) begin
                  state <= SET;
                  done  <= 1'b0;
                  blank <= 1'b0;
               end else blank <= ~blank;
         endcase
      end
   end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed stimulus with a queued-expectation scoreboard for countdown_timer
module tb_countdown_timer;
   logic       CLK2 = 1'b0;
   logic       RESET = 1'b1, ADJ = 1'b0, SEL = 1'b0, START = 1'b0, PAUSE = 1'b0;
   logic [3:0] d0, d1, d2, d3;
   logic       done, blank;
   int         checks = 0, errors = 0;
   typedef struct {logic [17:0] v; string nm;} exp_t;
   exp_t       q[$];

   countdown_timer dut (
      .CLK2(CLK2), .RESET(RESET), .ADJ(ADJ), .SEL(SEL), .START(START), .PAUSE(PAUSE),
      .d0(d0), .d1(d1), .d2(d2), .d3(d3), .done(done), .blank(blank)
   );

   always #5 CLK2 = ~CLK2;

   function automatic logic [7:0] bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   // in = {RESET, ADJ, SEL, START, PAUSE}; e = {mm, ss, done, blank} expected after the edge
   task automatic st(input logic [4:0] in, input logic chk, input logic [17:0] e, input string nm);
      @(negedge CLK2);
      {RESET, ADJ, SEL, START, PAUSE} = in;
      @(posedge CLK2);
      if (chk) q.push_back('{e, nm});
   endtask

   task automatic tm(input logic [4:0] in, input int mm, input int ss, input logic dn, input logic bl, input string nm);
      st(in, 1'b1, {bcd(mm), bcd(ss), dn, bl}, nm);
   endtask

   // monitor: outputs are settled at the falling edge, compare against queued expectations
   always @(negedge CLK2) begin
      while (q.size() > 0) begin
         exp_t x;
         x = q.pop_front();
         checks++;
         if ({d3, d2, d1, d0, done, blank} !== x.v) begin
            errors++;
            $display("FAIL %s got %h exp %h", x.nm, {d3, d2, d1, d0, done, blank}, x.v);
         end
      end
   end

   localparam logic [4:0] IDLE = 5'b00000, RST = 5'b10000, ASEC = 5'b01100, AMIN = 5'b01000,
                          GO = 5'b00010, PZ = 5'b00001, PADJ = 5'b01101;

   initial begin
      tm(RST, 0, 0, 0, 0, "reset");
      for (int i = 1; i <= 60; i++) tm(ASEC, 0, i % 60, 0, 0, "sec_wrap");
      for (int i = 1; i <= 61; i++) tm(AMIN, i % 60, 0, 0, 0, "min_wrap");
      tm(GO,   1, 0,  0, 0, "b1_e0");
      tm(IDLE, 1, 0,  0, 0, "b1_e1");
      tm(IDLE, 0, 59, 0, 0, "b1_e2");
      tm(RST,  0, 0,  0, 0, "reset_run");
      for (int i = 1; i <= 10; i++) tm(AMIN, i, 0, 0, 0, "set_10");
      tm(GO,   10, 0,  0, 0, "b10_e0");
      tm(IDLE, 10, 0,  0, 0, "b10_e1");
      tm(IDLE, 9,  59, 0, 0, "b10_e2");
      tm(RST,  0,  0,  0, 0, "reset2");
      tm(ASEC, 0,  1,  0, 0, "set_01");
      tm(ASEC, 0,  2,  0, 0, "set_02");
      tm(GO,   0,  2,  0, 0, "x_e0");
      tm(IDLE, 0,  2,  0, 0, "x_e1");
      tm(IDLE, 0,  1,  0, 0, "x_e2");
      tm(IDLE, 0,  1,  0, 0, "x_e3");
      tm(IDLE, 0,  0,  1, 0, "x_e4");
      tm(PZ,   0,  0,  1, 1, "x_e5");
      tm(IDLE, 0,  0,  1, 0, "x_e6");
      tm(IDLE, 0,  0,  1, 1, "x_e7");
      tm(GO,   0,  0,  0, 0, "x_ack");
      tm(IDLE, 0,  0,  0, 0, "set_idle");
      tm(GO,   0,  0,  0, 0, "zero_start");
      tm(IDLE, 0,  0,  0, 0, "zero_stay1");
      tm(IDLE, 0,  0,  0, 0, "zero_stay2");
      tm(RST,  0,  0,  0, 0, "reset3");
      for (int i = 1; i <= 5; i++) tm(ASEC, 0, i, 0, 0, "set_05");
      tm(GO,   0, 5, 0, 0, "p_e0");
      tm(IDLE, 0, 5, 0, 0, "p_e1");
      tm(IDLE, 0, 4, 0, 0, "p_e2");
      tm(IDLE, 0, 4, 0, 0, "p_e3");
      for (int i = 0; i < 10; i++) tm(PZ, 0, 4, 0, 0, "p_hold");
      tm(IDLE, 0, 4, 0, 0, "p_resume");
      tm(IDLE, 0, 3, 0, 0, "p_dec");
      tm(PZ,   0, 3, 0, 0, "h_hold");
      tm(PADJ, 0, 3, 0, 0, "h_to_set");
      tm(ASEC, 0, 4, 0, 0, "h_set_adj");
      tm(RST,  0, 0, 0, 0, "reset4");
      for (int i = 1; i <= 3; i++) tm(AMIN, i, 0, 0, 0, "set_3m");
      for (int i = 1; i <= 17; i++) tm(ASEC, 3, i, 0, 0, "set_17s");
      tm(GO,   3, 17, 0, 0, "r_e0");
      tm(IDLE, 3, 17, 0, 0, "r_e1");
      tm(RST,  0, 0,  0, 0, "reset_mid");
      tm(IDLE, 0, 0,  0, 0, "after_rst1");
      tm(IDLE, 0, 0,  0, 0, "after_rst2");
      @(negedge CLK2);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d exp 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
